// File: rtl/sort_stream_collector.sv
// sort_stream_collector
//
// Captures one stream of N_ELEM signed elements from a sorter's serial
// output into a local buffer. It checks on the fly that the stream is
// non-decreasing and counts the cycles from arming to the final capture.
// The buffer can be read back through a registered read port in any state.
//
// Ports
//   clk            clock; all state updates on the rising edge
//   rst            synchronous reset, active low
//   start_i        one-cycle pulse that arms a new collection
//   data_serial_i  signed element from the sorter
//   data_valid_i   qualifies data_serial_i
//   rd_addr_i      buffer read address
//   rd_data_o      buffer read data, one cycle after rd_addr_i (0 when out of range)
//   count_o        number of elements captured so far
//   done_o         high while all N_ELEM elements are held
//   sorted_ok_o    stream was non-decreasing (meaningful while done_o)
//   err_idx_o      index of the first element smaller than its predecessor, else 0
//   overflow_o     sticky: a valid beat arrived while done
//   latency_o      cycles from arming to the final capture, saturating
module sort_stream_collector #(
  parameter int N_ELEM = 10,
  parameter int DATA_W = 32,
  parameter int LAT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start_i,
  input  logic signed [DATA_W-1:0] data_serial_i,
  input  logic                     data_valid_i,
  input  logic [3:0]               rd_addr_i,
  output logic signed [DATA_W-1:0] rd_data_o,
  output logic [3:0]               count_o,
  output logic                     done_o,
  output logic                     sorted_ok_o,
  output logic [3:0]               err_idx_o,
  output logic                     overflow_o,
  output logic [LAT_W-1:0]         latency_o
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ARMED   = 2'd1;
  localparam logic [1:0] S_COLLECT = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  localparam logic [3:0] LAST_IDX = 4'(N_ELEM - 1);

  logic [1:0]               state;
  logic signed [DATA_W-1:0] mem [N_ELEM];
  logic signed [DATA_W-1:0] prev;     // last captured element
  logic [3:0]               err_pos;  // first violation index seen so far, 0 = none

  logic                     wr_en;
  logic [3:0]               wr_idx;
  logic                     viol;
  logic [3:0]               err_pos_next;
  logic                     last_beat;
  logic signed [DATA_W-1:0] rd_mux;

  function automatic logic [LAT_W-1:0] sat_inc(input logic [LAT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_comb begin
    wr_en        = !start_i && data_valid_i && (state == S_ARMED || state == S_COLLECT);
    wr_idx       = (state == S_ARMED) ? 4'd0 : count_o;
    // Index 0 can never be a violation, so a zero err_pos safely means "none yet".
    viol         = (state == S_COLLECT) && data_valid_i && (data_serial_i < prev);
    err_pos_next = (viol && err_pos == 4'd0) ? count_o : err_pos;
    last_beat    = (state == S_COLLECT) && data_valid_i && (count_o == LAST_IDX);
  end

  // Addresses at or beyond N_ELEM match no entry and fall through to zero.
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < N_ELEM; i++) begin
      if (rd_addr_i == 4'(i)) rd_mux = mem[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= S_IDLE;
      count_o     <= '0;
      latency_o   <= '0;
      err_pos     <= '0;
      err_idx_o   <= '0;
      sorted_ok_o <= 1'b0;
      done_o      <= 1'b0;
      overflow_o  <= 1'b0;
      prev        <= '0;
      rd_data_o   <= '0;
      for (int i = 0; i < N_ELEM; i++) mem[i] <= '0;
    end else begin
      // Read stage: one registered cycle from address to data.
      rd_data_o <= rd_mux;

      for (int i = 0; i < N_ELEM; i++) begin
        if (wr_en && wr_idx == 4'(i)) mem[i] <= data_serial_i;
      end

      if (start_i) begin
        // Arming always wins, even over a coincident beat; the buffer is kept.
        state       <= S_ARMED;
        count_o     <= '0;
        latency_o   <= '0;
        err_pos     <= '0;
        err_idx_o   <= '0;
        sorted_ok_o <= 1'b0;
        done_o      <= 1'b0;
        overflow_o  <= 1'b0;
      end else begin
        case (state)
          S_ARMED: begin
            latency_o <= sat_inc(latency_o);
            if (data_valid_i) begin
              prev    <= data_serial_i;
              count_o <= 4'd1;
              state   <= S_COLLECT;
            end
          end
          S_COLLECT: begin
            latency_o <= sat_inc(latency_o);
            if (data_valid_i) begin
              prev    <= data_serial_i;
              count_o <= count_o + 4'd1;
              err_pos <= err_pos_next;
              // Status outputs are published only on the transition into DONE,
              // so they stay stable during collection.
              if (last_beat) begin
                state       <= S_DONE;
                done_o      <= 1'b1;
                sorted_ok_o <= (err_pos_next == 4'd0);
                err_idx_o   <= err_pos_next;
              end
            end
          end
          S_DONE: begin
            if (data_valid_i) overflow_o <= 1'b1;
          end
          default: ;  // IDLE ignores data until armed
        endcase
      end
    end
  end

endmodule
